// File: rtl/data_memory_ctrl.sv
// Byte-addressable RV32 data memory with sub-word load/store, sign/zero extension,
// alignment/range checking and a valid/ready handshake with configurable wait states.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | READY=1; a VALID request is latched and the wait counter loaded
// BUSY  | READY=0; counts wait states down, access happens when count is 0
module data_memory_ctrl #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int MEM_BYTES     = 4096,
  parameter int WAIT_STATES   = 0
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     VALID,
  input  logic                     WE,
  input  logic [2:0]               FUNCT3,
  input  logic [ADDRESS_WIDTH-1:0] A,
  input  logic [31:0]              WD,
  output logic                     READY,
  output logic [31:0]              RD,
  output logic                     DONE,
  output logic                     ERR
);

  localparam int IDX_W = $clog2(MEM_BYTES);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                   state;
  logic [3:0]               cnt;
  logic                     we_q;
  logic [2:0]               f3_q;
  logic [ADDRESS_WIDTH-1:0] a_q;
  logic [31:0]              wd_q;

  logic [7:0] mem [MEM_BYTES];

  logic [IDX_W-1:0] i0, i1, i2, i3;
  logic             illegal, misaligned, out_of_range, acc_err;
  logic             access_now;
  logic [7:0]       b0;
  logic [15:0]      h0;
  logic [31:0]      w0;
  logic [31:0]      load_data;

  // Byte lanes of the latched address; only meaningful once alignment has passed.
  assign i0 = a_q[IDX_W-1:0];
  assign i1 = i0 | IDX_W'(1);
  assign i2 = (i0 & ~IDX_W'(3)) | IDX_W'(2);
  assign i3 = i0 | IDX_W'(3);

  assign access_now = (state == BUSY) && (cnt == 4'd0);

  always_comb begin
    illegal      = 1'b0;
    misaligned   = 1'b0;
    out_of_range = 1'b0;
    if (we_q)
      illegal = !(f3_q inside {3'b000, 3'b001, 3'b010});
    else
      illegal = f3_q inside {3'b011, 3'b110, 3'b111};
    misaligned   = ((f3_q[1:0] == 2'b01) && a_q[0]) ||
                   ((f3_q[1:0] == 2'b10) && (a_q[1:0] != 2'b00));
    // Full-width compare so high address bits flag an error instead of aliasing.
    out_of_range = {1'b0, a_q} >= (ADDRESS_WIDTH+1)'(MEM_BYTES);
    acc_err      = illegal || misaligned || out_of_range;
  end

  always_comb begin
    b0        = mem[i0];
    h0        = {mem[i1], mem[i0]};
    w0        = {mem[i3], mem[i2], mem[i1], mem[i0]};
    load_data = 32'd0;
    case (f3_q)
      3'b000:  load_data = {{24{b0[7]}}, b0};
      3'b001:  load_data = {{16{h0[15]}}, h0};
      3'b010:  load_data = w0;
      3'b100:  load_data = {24'd0, b0};
      3'b101:  load_data = {16'd0, h0};
      default: load_data = 32'd0;
    endcase
  end

  // Storage is deliberately not reset; a reset during BUSY suppresses the write.
  always_ff @(posedge CLK) begin
    if (!RST && access_now && we_q && !acc_err) begin
      case (f3_q[1:0])
        2'b00: mem[i0] <= wd_q[7:0];
        2'b01: begin
          mem[i0] <= wd_q[7:0];
          mem[i1] <= wd_q[15:8];
        end
        2'b10: begin
          mem[i0] <= wd_q[7:0];
          mem[i1] <= wd_q[15:8];
          mem[i2] <= wd_q[23:16];
          mem[i3] <= wd_q[31:24];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      READY <= 1'b1;
      RD    <= 32'd0;
      DONE  <= 1'b0;
      ERR   <= 1'b0;
      cnt   <= 4'd0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (VALID) begin
            we_q  <= WE;
            f3_q  <= FUNCT3;
            a_q   <= A;
            wd_q  <= WD;
            cnt   <= 4'(WAIT_STATES);
            state <= BUSY;
            READY <= 1'b0;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            DONE  <= 1'b1;
            ERR   <= acc_err;
            RD    <= (acc_err || we_q) ? 32'd0 : load_data;
            state <= IDLE;
            READY <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          READY <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: a zero-wait and a three-wait instance, a vector table
// through a scoreboard, plus hand sequences for busy hold-off and reset mid-access.
module tb_data_memory_ctrl;

  logic        CLK = 1'b0;
  logic        rst0, rst3, valid0, valid3;
  logic        we;
  logic [2:0]  f3;
  logic [31:0] a, wd;
  logic        ready0, ready3, done0, done3, err0, err3;
  logic [31:0] rd0, rd3;

  logic        sel;
  logic        cur_ready, cur_done, cur_err;
  logic [31:0] cur_rd;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  always #5 CLK = ~CLK;

  data_memory_ctrl #(.ADDRESS_WIDTH(32), .MEM_BYTES(4096), .WAIT_STATES(0)) dut0 (
    .CLK(CLK), .RST(rst0), .VALID(valid0), .WE(we), .FUNCT3(f3), .A(a), .WD(wd),
    .READY(ready0), .RD(rd0), .DONE(done0), .ERR(err0)
  );

  data_memory_ctrl #(.ADDRESS_WIDTH(32), .MEM_BYTES(4096), .WAIT_STATES(3)) dut3 (
    .CLK(CLK), .RST(rst3), .VALID(valid3), .WE(we), .FUNCT3(f3), .A(a), .WD(wd),
    .READY(ready3), .RD(rd3), .DONE(done3), .ERR(err3)
  );

  always_comb begin
    cur_ready = sel ? ready3 : ready0;
    cur_done  = sel ? done3  : done0;
    cur_err   = sel ? err3   : err0;
    cur_rd    = sel ? rd3    : rd0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input logic w, input logic [2:0] f, input logic [31:0] ad,
                              input logic [31:0] d, input logic [31:0] r, input logic e);
    vec_t v;
    v.we = w; v.f3 = f; v.a = ad; v.wd = d; v.rd = r; v.err = e;
    tbl.push_back(v);
  endfunction

  // Called at the negedge following the accepting edge; waits for DONE and scores it.
  task automatic wait_done(input int ws, input string name);
    int   cyc;
    exp_t e;
    cyc = 1;
    while (!cur_done && cyc < 40) begin
      @(negedge CLK);
      cyc++;
    end
    if (!cur_done) begin
      chk({name, "_timeout"}, 32'(cur_done), 32'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      chk({name, "_latency"}, 32'(cyc), 32'(2 + ws));
      chk({name, "_ready"}, 32'(cur_ready), 32'd1);
      if (sb.size() == 0) begin
        chk({name, "_sb_empty"}, 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk({name, "_rd"}, cur_rd, e.rd);
        chk({name, "_err"}, 32'(cur_err), 32'(e.err));
      end
    end
  endtask

  task automatic issue(input logic s, input vec_t v, input string name);
    exp_t e;
    sel = s;
    we = v.we; f3 = v.f3; a = v.a; wd = v.wd;
    if (s) valid3 = 1'b1; else valid0 = 1'b1;
    e.rd = v.rd; e.err = v.err;
    sb.push_back(e);
    @(negedge CLK);
    valid0 = 1'b0;
    valid3 = 1'b0;
    we = 1'b0; f3 = 3'b111; a = 32'hFFFF_FFFF; wd = 32'h5555_5555;
    wait_done(s ? 3 : 0, name);
  endtask

  initial begin
    vec_t v;
    exp_t e;
    int   n;

    sel = 1'b0;
    rst0 = 1'b1; rst3 = 1'b1; valid0 = 1'b0; valid3 = 1'b0;
    we = 1'b0; f3 = 3'b000; a = 32'd0; wd = 32'd0;

    //  we   f3      A              WD             RD             ERR
    add(1, 3'b010, 32'h10,        32'hDEADBEEF, 32'h00000000, 0);
    add(0, 3'b010, 32'h10,        32'h0,        32'hDEADBEEF, 0);
    add(0, 3'b000, 32'h13,        32'h0,        32'hFFFFFFDE, 0);
    add(0, 3'b100, 32'h13,        32'h0,        32'h000000DE, 0);
    add(0, 3'b001, 32'h10,        32'h0,        32'hFFFFBEEF, 0);
    add(0, 3'b101, 32'h12,        32'h0,        32'h0000DEAD, 0);
    add(1, 3'b000, 32'h11,        32'h000000AA, 32'h00000000, 0);
    add(0, 3'b010, 32'h10,        32'h0,        32'hDEADAAEF, 0);
    add(0, 3'b000, 32'h11,        32'h0,        32'hFFFFFFAA, 0);
    add(0, 3'b010, 32'h12,        32'h0,        32'h00000000, 1);
    add(1, 3'b001, 32'h11,        32'h0000FFFF, 32'h00000000, 1);
    add(0, 3'b010, 32'h1000,      32'h0,        32'h00000000, 1);
    add(0, 3'b011, 32'h10,        32'h0,        32'h00000000, 1);
    add(1, 3'b100, 32'h10,        32'h0,        32'h00000000, 1);
    add(1, 3'b010, 32'h10000010,  32'h11111111, 32'h00000000, 1);
    add(0, 3'b010, 32'h10,        32'h0,        32'hDEADAAEF, 0);
    add(1, 3'b010, 32'hFFC,       32'h01234567, 32'h00000000, 0);
    add(0, 3'b010, 32'hFFC,       32'h0,        32'h01234567, 0);
    add(0, 3'b100, 32'hFFF,       32'h0,        32'h00000001, 0);
    add(0, 3'b001, 32'hFFE,       32'h0,        32'h00000123, 0);

    repeat (3) @(negedge CLK);
    rst0 = 1'b0; rst3 = 1'b0;
    chk("rst_ready0", 32'(ready0), 32'd1);
    chk("rst_done0",  32'(done0),  32'd0);
    chk("rst_err0",   32'(err0),   32'd0);
    chk("rst_rd0",    rd0,         32'd0);
    chk("rst_ready3", 32'(ready3), 32'd1);
    chk("rst_done3",  32'(done3),  32'd0);
    chk("rst_err3",   32'(err3),   32'd0);
    chk("rst_rd3",    rd3,         32'd0);

    for (int i = 0; i < tbl.size(); i++)
      issue(1'b0, tbl[i], $sformatf("vec%0d", i));

    // Busy hold-off with VALID held, and back-to-back acceptance in the DONE cycle.
    sel = 1'b1;
    we = 1'b1; f3 = 3'b010; a = 32'h40; wd = 32'hCAFEF00D; valid3 = 1'b1;
    e.rd = 32'd0; e.err = 1'b0;
    sb.push_back(e);
    @(negedge CLK);
    we = 1'b0; a = 32'h44; wd = 32'h0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("busy_ready%0d", i), 32'(ready3), 32'd0);
      chk($sformatf("busy_done%0d", i),  32'(done3),  32'd0);
      @(negedge CLK);
    end
    chk("hold_done",  32'(done3),  32'd1);
    chk("hold_ready", 32'(ready3), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("hold_rd",  rd3,         e.rd);
      chk("hold_err", 32'(err3),   32'(e.err));
    end
    we = 1'b0; f3 = 3'b010; a = 32'h40;
    e.rd = 32'hCAFEF00D; e.err = 1'b0;
    sb.push_back(e);
    @(negedge CLK);
    valid3 = 1'b0;
    wait_done(3, "b2b");
    n = 0;
    repeat (8) begin
      @(negedge CLK);
      if (done3) n++;
    end
    chk("no_extra_done", 32'(n), 32'd0);

    // Reset while a store is pending: write dropped, no DONE, VALID ignored under reset.
    v.we = 1; v.f3 = 3'b010; v.a = 32'h20; v.wd = 32'h0BADF00D; v.rd = 32'd0; v.err = 0;
    issue(1'b1, v, "pre_sw");
    v.we = 0; v.rd = 32'h0BADF00D;
    issue(1'b1, v, "pre_lw");
    we = 1'b1; f3 = 3'b010; a = 32'h20; wd = 32'h12345678; valid3 = 1'b1;
    @(negedge CLK);
    valid3 = 1'b0;
    @(negedge CLK);
    rst3 = 1'b1; valid3 = 1'b1; wd = 32'hFFFFFFFF;
    @(negedge CLK);
    chk("mid_rst_ready", 32'(ready3), 32'd1);
    chk("mid_rst_rd",    rd3,         32'd0);
    chk("mid_rst_done",  32'(done3),  32'd0);
    @(negedge CLK);
    rst3 = 1'b0; valid3 = 1'b0;
    n = 0;
    repeat (8) begin
      if (done3) n++;
      @(negedge CLK);
    end
    chk("rst_no_done",   32'(n),      32'd0);
    chk("rst_ready_idle", 32'(ready3), 32'd1);
    v.we = 0; v.f3 = 3'b010; v.a = 32'h20; v.rd = 32'h0BADF00D; v.err = 0;
    issue(1'b1, v, "post_rst_lw");

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Byte-addressable RV32 data memory with load/store width decoding, sign/zero extension, alignment and range checking, and a valid/ready request interface with configurable wait states. It sits between the execute stage and writeback. It is the parametrised successor of the word-only data memory: it adds sub-word access, error reporting, registered read data and multi-cycle latency for stall testing.

## Interface
- ADDRESS_WIDTH, 32: width of byte address input A.
- MEM_BYTES, 4096: storage size in bytes. Power of two, >= 4.
- WAIT_STATES, 0: extra busy cycles per access. Range 0..15.
- CLK  input  1: single clock; everything is updated on the rising edge.
- RST  input  1: reset is synchronous and active-high.
- VALID  input  1: request present.
- WE  input  1: 1 = store, 0 = load.
- FUNCT3  input  3: RV32 load/store funct3.
- A  input  ADDRESS_WIDTH: byte address.
- WD  input  32: store data. Low byte/half used for SB/SH.
- READY  output  1: block can accept a request this cycle.
- RD  output  32: registered, extended load result.
- DONE  output  1: one-cycle pulse marking completion of an accepted request.
- ERR  output  1: qualifies DONE; request was illegal and had no effect.

## Operation
- Storage: MEM_BYTES bytes, little-endian, not cleared by reset.
- FSM states:
  - IDLE: READY=1. On VALID && READY && !RST, latch A, WD, WE, FUNCT3; load the wait counter with WAIT_STATES; go to BUSY.
  - BUSY: READY=0. While counter != 0, decrement it. When counter == 0, the next edge performs the access, registers RD/ERR, sets DONE=1 and returns to IDLE.
- The access is performed at that edge, not at acceptance.
- Loads:
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
- Stores:
  - 000 SB: write byte A.
  - 001 SH: write bytes A, A+1.
  - 010 SW: write bytes A..A+3.
- Error conditions (ERR=1):
  - Illegal encoding: load FUNCT3 in {011,110,111}, or store FUNCT3 not in {000,001,010}.
  - Misaligned: half access with A[0]=1; word access with A[1:0]!=0.
  - Out of range: A >= MEM_BYTES. Upper address bits are checked, never wrapped.
- On error: no byte is written, RD=0, DONE still pulses.
- After a store, RD is 0.
- RD holds its value until the next completion or reset. ERR holds until the next DONE.

## Timing
- Reset values: state IDLE, READY=1, RD=0, DONE=0, ERR=0, counter=0.
- While RST=1, VALID is ignored.
- Latency: accepted at edge N, DONE high in the cycle after edge N+1+WAIT_STATES.
- RD and ERR are valid in the same cycle as DONE.
- DONE cycle is spent in IDLE, so READY=1 and a new request may be accepted in that same cycle.
- Throughput: one request per 2+WAIT_STATES cycles.
- Inputs other than VALID are don't-care after acceptance; the latched copy is used.
- Store then load to the same address back-to-back: the load returns the new data, because the store commits before the load is accepted.
- Reset in BUSY:
  - The pending access is dropped (write not performed) and no DONE is generated.
  - A store that already completed is not rolled back.
- VALID while READY=0 is ignored; the requester must hold the request until accepted.

## Test plan
- Reset then SW A=0x10 WD=0xDEADBEEF, then LW A=0x10 -> DONE with ERR=0, RD=0xDEADBEEF. With WAIT_STATES=0, DONE appears 2 cycles after each acceptance.
- After that store:
  - LB A=0x13 -> RD=0xFFFFFFDE.
  - LBU A=0x13 -> RD=0x000000DE.
  - LH A=0x10 -> RD=0xFFFFBEEF.
  - LHU A=0x12 -> RD=0x0000DEAD.
- SB A=0x11 WD=0x000000AA, then LW A=0x10 -> RD=0xDEADAAEF. Only byte 1 changes.
- Error cases, each -> DONE, ERR=1, RD=0:
  - LW A=0x12, and SH A=0x11: misaligned.
  - LW A=MEM_BYTES: out of range.
  - FUNCT3=011 load: illegal encoding.
  - After the failed stores, reading 0x10 -> RD still 0xDEADAAEF.
- WAIT_STATES=3:
  - Accepted request -> READY low 4 cycles, DONE in the 5th cycle.
  - VALID held during BUSY is not accepted.
  - A second request is accepted in the DONE cycle.
- WAIT_STATES=3, SW A=0x20 WD=0x12345678, RST pulsed 2 cycles after acceptance -> no DONE, READY=1 after reset. A subsequent LW A=0x20 returns the prior contents, unchanged.
